// File: rtl/bnn_pkg.sv
// Shared types and defaults for the BNN image front end.
package bnn_pkg;

  // Frame assembler states; the numeric values are visible on state_code.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int         IMG_BITS_DEF    = 900;
  localparam int         FRAME_BYTES_DEF = (IMG_BITS_DEF + 7) / 8;
  localparam logic [7:0] CMD_START_DEF   = 8'hA5;
  localparam int         COUNT_W         = 7;

  // Number of image bits a byte slot can hold when its top bit sits at index hi.
  // Only the final slot of a frame is ever narrower than a full byte.
  function automatic int slice_width(input int hi);
    return (hi >= 7) ? 8 : hi + 1;
  endfunction

endpackage

// File: rtl/idle_timeout_counter.sv
// Saturating idle counter: counts cycles without a kick while run is high.
module idle_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  input  logic run,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Restart on activity or when not armed; otherwise climb and stick at the limit.
  always_comb begin
    count_next = count_reg;
    if (!run || kick) begin
      count_next = '0;
    end else if (count_reg != LIMIT) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = run && (count_reg == LIMIT);

endmodule

// File: rtl/image_frame_assembler.sv
// Collects a command-framed stream of SPI bytes into one wide image word.
module image_frame_assembler
  import bnn_pkg::*;
#(
  parameter int         IMG_BITS       = IMG_BITS_DEF,
  parameter int         FRAME_BYTES    = FRAME_BYTES_DEF,
  parameter logic [7:0] CMD_START      = CMD_START_DEF,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          spi_rx_data,
  input  logic                spi_byte_valid,
  output logic                byte_taken,
  output logic                rx_enable,
  input  logic                clear,
  output logic [IMG_BITS-1:0] img_out,
  output logic                img_valid,
  input  logic                img_taken,
  output logic [6:0]          byte_count,
  output logic                frame_error,
  output logic [1:0]          state_code
);

  state_t               state_reg;
  state_t               state_next;
  logic                 byte_taken_reg;
  logic [IMG_BITS-1:0]  img_reg;
  logic [IMG_BITS-1:0]  img_next;
  logic [COUNT_W-1:0]   byte_count_reg;
  logic                 frame_error_reg;

  logic accept;
  logic is_cmd;
  logic start;
  logic wr;
  logic last_byte;
  logic clr_img;
  logic expired;

  // A byte is consumed at most every other cycle, never while clear is pending.
  assign accept    = spi_byte_valid & rx_enable & ~byte_taken_reg & ~clear;
  assign is_cmd    = (spi_rx_data == CMD_START);
  assign start     = accept & is_cmd & ((state_reg == ST_IDLE) | (state_reg == ST_ERROR));
  assign wr        = accept & (state_reg == ST_RECV);
  assign last_byte = (byte_count_reg == COUNT_W'(FRAME_BYTES - 1));
  assign clr_img   = clear | start;

  idle_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .kick   (wr),
    .run    (state_reg == ST_RECV),
    .expired(expired)
  );

  // One write slot per payload byte; the last slot keeps only the bits that fit.
  for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_byte
    localparam int                 HI  = IMG_BITS - 1 - 8 * gi;
    localparam int                 NB  = slice_width(HI);
    localparam logic [COUNT_W-1:0] IDX = COUNT_W'(gi);
    assign img_next[HI -: NB] = clr_img ? '0 :
                                (wr && (byte_count_reg == IDX)) ? spi_rx_data[7 -: NB] :
                                img_reg[HI -: NB];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; clear overrides every other event.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (start) state_next = ST_RECV;
        ST_RECV: begin
          if (wr && last_byte) state_next = ST_FULL;
          else if (!wr && expired) state_next = ST_ERROR;
        end
        ST_FULL:  if (img_taken) state_next = ST_IDLE;
        ST_ERROR: if (start) state_next = ST_RECV;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs: backpressure while a finished image waits.
  always_comb begin
    rx_enable  = (state_reg != ST_FULL);
    img_valid  = (state_reg == ST_FULL);
    state_code = state_reg;
  end

  // Datapath: image word, payload counter, acknowledge pulse and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_taken_reg  <= 1'b0;
      img_reg         <= '0;
      byte_count_reg  <= '0;
      frame_error_reg <= 1'b0;
    end else begin
      byte_taken_reg <= accept;
      img_reg        <= img_next;
      if (clear || start) begin
        byte_count_reg  <= '0;
        frame_error_reg <= 1'b0;
      end else if (wr) begin
        byte_count_reg <= byte_count_reg + 1'b1;
      end else if ((state_reg == ST_FULL) && img_taken) begin
        byte_count_reg <= '0;
      end else if ((state_reg == ST_RECV) && expired) begin
        frame_error_reg <= 1'b1;
      end
    end
  end

  assign byte_taken  = byte_taken_reg;
  assign img_out     = img_reg;
  assign byte_count  = byte_count_reg;
  assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_image_frame_assembler.sv
// Self-checking bench for image_frame_assembler (short timeout build).
module tb_image_frame_assembler;

  localparam int IMG = 900;
  localparam int FB  = 113;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     spi_rx_data = 8'h00;
  logic           spi_byte_valid = 1'b0;
  logic           byte_taken;
  logic           rx_enable;
  logic           clear = 1'b0;
  logic [IMG-1:0] img_out;
  logic           img_valid;
  logic           img_taken = 1'b0;
  logic [6:0]     byte_count;
  logic           frame_error;
  logic [1:0]     state_code;

  always #5 clk = ~clk;

  image_frame_assembler #(
    .IMG_BITS(IMG), .FRAME_BYTES(FB), .CMD_START(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spi_rx_data(spi_rx_data), .spi_byte_valid(spi_byte_valid),
    .byte_taken(byte_taken), .rx_enable(rx_enable), .clear(clear), .img_out(img_out),
    .img_valid(img_valid), .img_taken(img_taken), .byte_count(byte_count),
    .frame_error(frame_error), .state_code(state_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Edge monitors: acknowledge pulses, over-long pulses and img_valid rises.
  int   bt_pulses = 0;
  int   bt_long   = 0;
  int   iv_rises  = 0;
  logic bt_prev   = 1'b0;
  logic iv_prev   = 1'b0;
  always @(negedge clk) begin
    if (byte_taken) bt_pulses++;
    if (byte_taken && bt_prev) bt_long++;
    if (img_valid && !iv_prev) iv_rises++;
    bt_prev = byte_taken;
    iv_prev = img_valid;
  end

  typedef struct {
    logic [7:0] data;
    logic [1:0] exp_state;
    int         exp_count;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [IMG-1:0] exp);
    int first;
    n_tests++;
    if (img_out !== exp) begin
      n_fail++;
      first = -1;
      for (int i = IMG - 1; i >= 0; i--)
        if (first < 0 && img_out[i] !== exp[i]) first = i;
      $display("FAIL %s: img_out differs, first at bit %0d got %b expected %b",
               name, first, img_out[first], exp[first]);
    end
  endtask

  // Reference image: byte k fills bits 899-8k downward, MSB first, dropping bits past 0.
  function automatic logic [IMG-1:0] model_img(input logic [7:0] q[$]);
    logic [IMG-1:0] r;
    int idx;
    r = '0;
    for (int k = 0; k < q.size(); k++)
      for (int b = 0; b < 8; b++) begin
        idx = IMG - 1 - 8 * k - b;
        if (idx >= 0) r[idx] = q[k][7 - b];
      end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int n;
    spi_rx_data    = d;
    spi_byte_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!byte_taken && n < 20);
    spi_byte_valid = 1'b0;
    check("byte_ack", byte_taken, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; clear = 1'b0; spi_byte_valid = 1'b0; img_taken = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, state_code, 0);
    check({tag, "_img_valid"}, img_valid, 0);
    check({tag, "_byte_taken"}, byte_taken, 0);
    check({tag, "_byte_count"}, byte_count, 0);
    check({tag, "_frame_error"}, frame_error, 0);
    check({tag, "_rx_enable"}, rx_enable, 1);
    check_img({tag, "_img"}, '0);
  endtask

  task automatic release_image(input string tag, input logic [IMG-1:0] exp);
    img_taken = 1'b1;
    tick();
    img_taken = 1'b0;
    check({tag, "_rel_state"}, state_code, 0);
    check({tag, "_rel_valid"}, img_valid, 0);
    check({tag, "_rel_count"}, byte_count, 0);
    check_img({tag, "_rel_img"}, exp);
  endtask

  // Garbage, command, then a full payload with random inter-byte gaps.
  task automatic run_random_frame(input string tag);
    logic [7:0] q[$];
    logic [7:0] d;
    logic [IMG-1:0] exp;
    int ng;
    ng = int'($urandom_range(0, 3));
    for (int i = 0; i < ng; i++) begin
      d = 8'($urandom);
      if (d == 8'hA5) d = 8'h5A;
      send_byte(d);
      check({tag, "_garbage_state"}, state_code, 0);
    end
    send_byte(8'hA5);
    for (int k = 0; k < FB; k++) begin
      repeat ($urandom_range(0, 4)) tick();
      d = 8'($urandom);
      q.push_back(d);
      send_byte(d);
    end
    exp = model_img(q);
    check({tag, "_state"}, state_code, 2);
    check({tag, "_valid"}, img_valid, 1);
    check({tag, "_count"}, byte_count, FB);
    check_img({tag, "_img"}, exp);
    $display("[TB] %s: %0d garbage bytes, %0d payload bytes assembled", tag, ng, FB);
    release_image(tag, exp);
  endtask

  initial begin
    logic [7:0]     q[$];
    logic [7:0]     d;
    logic [IMG-1:0] exp;
    vec_t           vecs[4];
    int             p0, bad, first, iv0;

    // Reset state
    reset_dut();
    check_reset("reset");
    $display("[TB] reset values checked");

    // Frame of all ones, then backpressure hold
    p0 = bt_pulses;
    send_byte(8'hA5);
    for (int k = 0; k < FB; k++) send_byte(8'hFF);
    check("ones_valid", img_valid, 1);
    check("ones_state", state_code, 2);
    check("ones_count", byte_count, FB);
    check_img("ones_img", {IMG{1'b1}});
    tick();
    check("ones_ack_pulses", bt_pulses - p0, FB + 1);
    check("ones_ack_single", bt_long, 0);
    $display("[TB] all-ones frame assembled");

    spi_rx_data = 8'h33;
    spi_byte_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rx_enable !== 1'b0 || byte_taken !== 1'b0 || img_valid !== 1'b1 ||
          img_out !== {IMG{1'b1}}) bad++;
    end
    spi_byte_valid = 1'b0;
    check("full_hold_bad_cycles", bad, 0);
    release_image("ones", {IMG{1'b1}});
    $display("[TB] backpressure hold and release checked");

    // Table: discarded bytes in IDLE, command, then payload
    vecs[0] = '{8'h11, 2'd0, 0};
    vecs[1] = '{8'h22, 2'd0, 0};
    vecs[2] = '{8'hA5, 2'd1, 0};
    vecs[3] = '{8'h80, 2'd1, 1};
    for (int i = 0; i < 4; i++) begin
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_state", i), state_code, vecs[i].exp_state);
      check($sformatf("vec%0d_count", i), byte_count, vecs[i].exp_count);
      $display("[TB] vec%0d data=%02h state=%0d count=%0d", i, vecs[i].data, state_code, byte_count);
    end
    q.delete();
    q.push_back(8'h80);
    for (int k = 1; k < FB; k++) begin
      send_byte(8'h00);
      q.push_back(8'h00);
    end
    exp = model_img(q);
    check("msb_state", state_code, 2);
    check("msb_bit899", img_out[IMG-1], 1);
    check_img("msb_img", exp);
    release_image("msb", exp);

    // img_taken ignored outside FULL; command value as payload
    img_taken = 1'b1;
    tick();
    img_taken = 1'b0;
    check("taken_idle_state", state_code, 0);
    send_byte(8'hA5);
    q.delete();
    send_byte(8'h5A); q.push_back(8'h5A);
    send_byte(8'hA5); q.push_back(8'hA5);
    check("cmd_payload_state", state_code, 1);
    check("cmd_payload_count", byte_count, 2);
    img_taken = 1'b1;
    tick();
    img_taken = 1'b0;
    check("taken_recv_state", state_code, 1);
    check("taken_recv_count", byte_count, 2);
    for (int k = 2; k < FB; k++) begin
      d = 8'($urandom);
      q.push_back(d);
      send_byte(d);
    end
    exp = model_img(q);
    check("cmdpay_state", state_code, 2);
    check_img("cmdpay_img", exp);
    // clear beats a simultaneous img_taken and zeroes the image
    clear = 1'b1;
    img_taken = 1'b1;
    tick();
    clear = 1'b0;
    img_taken = 1'b0;
    check("clear_full_state", state_code, 0);
    check("clear_full_valid", img_valid, 0);
    check_img("clear_full_img", '0);
    $display("[TB] command-as-payload frame and clear-over-taken checked");

    // Timeout into ERROR and recovery
    reset_dut();
    send_byte(8'hA5);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) check("pre_timeout_state", state_code, 1);
      if (first == 0 && state_code == 2'd3) first = k;
    end
    check("timeout_window", (first >= TO && first <= TO + 1), 1);
    check("timeout_ferr", frame_error, 1);
    check("error_rx_enable", rx_enable, 1);
    send_byte(8'h44);
    check("error_discard_state", state_code, 3);
    check("error_discard_ferr", frame_error, 1);
    send_byte(8'hA5);
    check("recover_state", state_code, 1);
    check("recover_ferr", frame_error, 0);
    check("recover_count", byte_count, 0);
    $display("[TB] timeout after %0d idle cycles, recovery checked", first);

    // clear with a byte pending at payload byte 60
    reset_dut();
    send_byte(8'hA5);
    for (int k = 0; k < 59; k++) send_byte(8'($urandom));
    tick();
    clear = 1'b1;
    spi_rx_data = 8'h77;
    spi_byte_valid = 1'b1;
    tick();
    clear = 1'b0;
    spi_byte_valid = 1'b0;
    check("clear_byte_taken", byte_taken, 0);
    check("clear_state", state_code, 0);
    check("clear_count", byte_count, 0);
    check("clear_ferr", frame_error, 0);
    check_img("clear_img", '0);
    $display("[TB] clear at byte 60 checked");

    // One-cycle reset at payload byte 40, then a clean frame
    reset_dut();
    send_byte(8'hA5);
    for (int k = 0; k < 39; k++) send_byte(8'($urandom));
    tick();
    iv0 = iv_rises;
    rst_n = 1'b0;
    spi_rx_data = 8'h99;
    spi_byte_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    spi_byte_valid = 1'b0;
    check_reset("midreset");
    run_random_frame("after_reset");
    tick();
    check("midreset_valid_rises", iv_rises - iv0, 1);

    // Randomized frames against the reference model
    for (int f = 0; f < 3; f++) run_random_frame($sformatf("rand%0d", f));
    check("ack_never_long", bt_long, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
